// File: rtl/mem_port_arbiter_if.sv
// Bundle of signals between the fetch/load-store requesters, the unified
// memory port and the arbiter that shares it.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [1:0]        d_size;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_size;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    // Arbiter side
    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_size, d_addr, d_wdata,
        input  mem_rvalid, mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_req, mem_we, mem_size, mem_addr, mem_wdata,
        output busy
    );

    // Requesters plus memory side
    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_size, d_addr, d_wdata,
        output mem_rvalid, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_req, mem_we, mem_size, mem_addr, mem_wdata,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and
// load/store, one transaction in flight, data-first with fetch anti-starvation.
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam int               CNT_W   = $clog2(MAX_DATA_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DATA_BURST);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic             owner_r;
    logic             store_r;
    logic [CNT_W-1:0] cnt_r;

    logic              grant_f_s;
    logic              grant_d_s;
    logic              data_mis_s;

    logic              if_gnt_s;
    logic              if_rvalid_s;
    logic [DATA_W-1:0] if_rdata_s;
    logic              d_gnt_s;
    logic              d_rvalid_s;
    logic [DATA_W-1:0] d_rdata_s;
    logic              d_err_s;
    logic              mem_req_s;
    logic              mem_we_s;
    logic [1:0]        mem_size_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic              busy_s;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            2'b00:   mis = 1'b0;
            2'b01:   mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

    function automatic logic [1:0] norm_size(input logic [1:0] size);
        logic [1:0] s;
        case (size)
            2'b00:   s = 2'b00;
            2'b01:   s = 2'b01;
            default: s = 2'b10;
        endcase
        return s;
    endfunction

    // Arbitration: only in IDLE, fetch wins a tie only once data has used up its burst
    always_comb begin
        grant_f_s  = 1'b0;
        grant_d_s  = 1'b0;
        data_mis_s = misaligned(bus.d_size, bus.d_addr[1:0]);
        if (!rst && (state_r == ST_IDLE)) begin
            if (bus.if_req && (!bus.d_req || (cnt_r == CNT_MAX))) begin
                grant_f_s = 1'b1;
            end else if (bus.d_req) begin
                grant_d_s = 1'b1;
            end else begin
                grant_f_s = 1'b0;
            end
        end else begin
            grant_f_s = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_f_s || (grant_d_s && !data_mis_s)) begin
                    state_nxt_s = ST_WAIT;
                end else if (grant_d_s) begin
                    state_nxt_s = ST_ERR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (bus.mem_rvalid) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_ERR:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Transaction owner, store flag and starvation counter, captured at grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_r <= 1'b0;
            store_r <= 1'b0;
            cnt_r   <= '0;
        end else if (grant_f_s) begin
            owner_r <= 1'b0;
            store_r <= 1'b0;
            cnt_r   <= '0;
        end else if (grant_d_s) begin
            owner_r <= 1'b1;
            store_r <= bus.d_we;
            if (!bus.if_req) begin
                cnt_r <= '0;
            end else if (cnt_r == CNT_MAX) begin
                cnt_r <= cnt_r;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end else begin
            owner_r <= owner_r;
            store_r <= store_r;
            cnt_r   <= cnt_r;
        end
    end

    // Output decode; everything is forced low while rst is asserted
    always_comb begin
        if_gnt_s    = grant_f_s;
        d_gnt_s     = grant_d_s;
        if_rvalid_s = 1'b0;
        if_rdata_s  = '0;
        d_rvalid_s  = 1'b0;
        d_rdata_s   = '0;
        d_err_s     = 1'b0;
        mem_req_s   = 1'b0;
        mem_we_s    = 1'b0;
        mem_size_s  = 2'b00;
        mem_addr_s  = '0;
        mem_wdata_s = '0;
        busy_s      = !rst && (state_r != ST_IDLE);

        if (grant_f_s) begin
            mem_req_s  = 1'b1;
            mem_size_s = 2'b10;
            mem_addr_s = bus.if_addr;
        end else if (grant_d_s && !data_mis_s) begin
            mem_req_s   = 1'b1;
            mem_we_s    = bus.d_we;
            mem_size_s  = norm_size(bus.d_size);
            mem_addr_s  = bus.d_addr;
            mem_wdata_s = bus.d_wdata;
        end else begin
            mem_req_s = 1'b0;
        end

        // Response is passed through in the same cycle it arrives
        case (state_r)
            ST_WAIT: begin
                if (!rst && bus.mem_rvalid) begin
                    if (owner_r) begin
                        d_rvalid_s = 1'b1;
                        d_rdata_s  = store_r ? '0 : bus.mem_rdata;
                    end else begin
                        if_rvalid_s = 1'b1;
                        if_rdata_s  = bus.mem_rdata;
                    end
                end else begin
                    d_rvalid_s = 1'b0;
                end
            end
            ST_ERR: begin
                if (!rst) begin
                    d_rvalid_s = 1'b1;
                    d_err_s    = 1'b1;
                end else begin
                    d_rvalid_s = 1'b0;
                end
            end
            default: d_rvalid_s = 1'b0;
        endcase
    end

    assign bus.if_gnt    = if_gnt_s;
    assign bus.if_rvalid = if_rvalid_s;
    assign bus.if_rdata  = if_rdata_s;
    assign bus.d_gnt     = d_gnt_s;
    assign bus.d_rvalid  = d_rvalid_s;
    assign bus.d_rdata   = d_rdata_s;
    assign bus.d_err     = d_err_s;
    assign bus.mem_req   = mem_req_s;
    assign bus.mem_we    = mem_we_s;
    assign bus.mem_size  = mem_size_s;
    assign bus.mem_addr  = mem_addr_s;
    assign bus.mem_wdata = mem_wdata_s;
    assign bus.busy      = busy_s;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: bench-side memory model plus a response
// scoreboard filled at grant time and drained when rvalid appears.
module tb_mem_port_arbiter;

    logic clk;
    logic rst;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .MAX_DATA_BURST(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic        is_d;
        logic [31:0] data;
        logic        err;
    } resp_t;

    resp_t       sb[$];
    int          checks    = 0;
    int          failures  = 0;
    int          mem_lat   = 1;
    int          pend_cnt  = -1;
    logic [31:0] pend_data = 32'h0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
        return (a ^ 32'h5A5A_0000) + 32'h0000_0101;
    endfunction

    function automatic logic bench_mis(input logic [1:0] size, input logic [31:0] a);
        if (size == 2'b00) return 1'b0;
        if (size == 2'b01) return a[0];
        return (a[1:0] != 2'b00);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to the next drive point and play the memory side
    task automatic cycle();
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = pend_data;
                pend_cnt       = -1;
            end
        end
    endtask

    task automatic observe();
        resp_t e;
        logic  mis;
        if (rst) begin
            chk("rst_ctrl", 32'({bus.if_gnt, bus.if_rvalid, bus.d_gnt, bus.d_rvalid, bus.d_err,
                                 bus.mem_req, bus.mem_we, bus.busy, bus.mem_size}), 32'h0);
            chk("rst_data", bus.if_rdata | bus.d_rdata | bus.mem_addr | bus.mem_wdata, 32'h0);
            return;
        end
        if (bus.if_rvalid || bus.d_rvalid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rvalid", 32'({bus.if_rvalid, bus.d_rvalid}), 32'h0);
            end else begin
                e = sb.pop_front();
                chk("rv_port", 32'(bus.d_rvalid), 32'(e.is_d));
                chk("rv_data", bus.d_rvalid ? bus.d_rdata : bus.if_rdata, e.data);
                chk("rv_err", 32'(bus.d_err), 32'(e.err));
            end
        end else begin
            chk("quiet_rdata", bus.if_rdata | bus.d_rdata, 32'h0);
            chk("quiet_err", 32'(bus.d_err), 32'h0);
        end
        if (bus.if_gnt) begin
            chk("dual_gnt", 32'(bus.d_gnt), 32'h0);
            sb.push_back('{is_d: 1'b0, data: mem_data(bus.if_addr), err: 1'b0});
            chk("f_mem_req", 32'(bus.mem_req), 32'h1);
            chk("f_mem_addr", bus.mem_addr, bus.if_addr);
            chk("f_mem_size", 32'(bus.mem_size), 32'h2);
            chk("f_mem_we", 32'(bus.mem_we), 32'h0);
        end else if (bus.d_gnt) begin
            mis = bench_mis(bus.d_size, bus.d_addr);
            sb.push_back('{is_d: 1'b1, data: (mis || bus.d_we) ? 32'h0 : mem_data(bus.d_addr), err: mis});
            chk("d_mem_req", 32'(bus.mem_req), 32'(!mis));
            if (!mis) begin
                chk("d_mem_addr", bus.mem_addr, bus.d_addr);
                chk("d_mem_we", 32'(bus.mem_we), 32'(bus.d_we));
                chk("d_mem_size", 32'(bus.mem_size), (bus.d_size == 2'b11) ? 32'h2 : 32'(bus.d_size));
                chk("d_mem_wdata", bus.mem_wdata, bus.d_wdata);
            end
        end else begin
            chk("nogrant_mem_req", 32'(bus.mem_req), 32'h0);
        end
        if (bus.mem_req) begin
            pend_cnt  = mem_lat;
            pend_data = mem_data(bus.mem_addr);
        end
    endtask

    task automatic settle();
        #1;
        observe();
    endtask

    logic [1:0]  order_exp [10];
    logic [1:0]  mis_size  [4];
    logic [31:0] mis_addr  [4];
    logic        mis_err   [4];
    int          k;

    initial begin
        order_exp = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
        mis_size  = '{2'b00, 2'b01, 2'b11, 2'b01};
        mis_addr  = '{32'h33, 32'h21, 32'h301, 32'h22};
        mis_err   = '{1'b0, 1'b1, 1'b1, 1'b0};

        rst = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = 32'h0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_size = 2'b10; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
        bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;

        // Reset: requests present but everything must stay low
        cycle();
        bus.if_req = 1'b1; bus.d_req = 1'b1;
        settle();
        cycle();
        rst = 1'b0; bus.if_req = 1'b0; bus.d_req = 1'b0;
        settle();
        chk("reset_busy", 32'(bus.busy), 32'h0);

        // 1: single fetch, latency 1
        mem_lat = 1;
        cycle(); bus.if_req = 1'b1; bus.if_addr = 32'h100; settle();
        chk("t1_if_gnt", 32'(bus.if_gnt), 32'h1);
        cycle(); settle();
        chk("t1_if_rvalid", 32'(bus.if_rvalid), 32'h1);
        chk("t1_if_rdata", bus.if_rdata, 32'hDEAD_BEEF);
        chk("t1_no_regrant", 32'({bus.if_gnt, bus.d_gnt}), 32'h0);
        cycle(); bus.if_req = 1'b0; settle();

        // 2: both requesters held, data burst then fetch
        k = 0;
        bus.if_addr = 32'h200; bus.d_addr = 32'h40; bus.d_we = 1'b0; bus.d_size = 2'b10;
        for (int i = 0; i < 20; i++) begin
            cycle(); bus.if_req = 1'b1; bus.d_req = 1'b1; settle();
            if ((bus.if_gnt || bus.d_gnt) && k < 10) begin
                chk("t2_order", 32'({bus.if_gnt, bus.d_gnt}), 32'(order_exp[k]));
                k++;
            end
        end
        chk("t2_grant_count", 32'(k), 32'd10);
        cycle(); bus.if_req = 1'b0; bus.d_req = 1'b0; settle();

        // 3: misaligned word store, fetch waiting
        cycle();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_size = 2'b10; bus.d_addr = 32'h202; bus.d_wdata = 32'hCAFE_0001;
        bus.if_req = 1'b1; bus.if_addr = 32'h300;
        settle();
        chk("t3_d_gnt", 32'(bus.d_gnt), 32'h1);
        chk("t3_mem_req", 32'(bus.mem_req), 32'h0);
        cycle(); bus.d_req = 1'b0; settle();
        chk("t3_d_rvalid", 32'(bus.d_rvalid), 32'h1);
        chk("t3_d_err", 32'(bus.d_err), 32'h1);
        chk("t3_d_rdata", bus.d_rdata, 32'h0);
        chk("t3_if_gnt_err", 32'(bus.if_gnt), 32'h0);
        cycle(); settle();
        chk("t3_if_gnt_after", 32'(bus.if_gnt), 32'h1);
        cycle(); bus.if_req = 1'b0; settle();
        cycle(); settle();

        // 4: half store, latency 3
        mem_lat = 3;
        cycle();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_size = 2'b01; bus.d_addr = 32'h10; bus.d_wdata = 32'h1234;
        settle();
        chk("t4_mem_we", 32'(bus.mem_we), 32'h1);
        chk("t4_mem_size", 32'(bus.mem_size), 32'h1);
        chk("t4_busy0", 32'(bus.busy), 32'h0);
        for (int i = 1; i <= 3; i++) begin
            cycle(); bus.d_req = 1'b0; settle();
            chk("t4_busy", 32'(bus.busy), 32'h1);
            chk("t4_if_rvalid", 32'(bus.if_rvalid), 32'h0);
            chk("t4_d_rvalid", 32'(bus.d_rvalid), (i == 3) ? 32'h1 : 32'h0);
        end
        cycle(); settle();
        chk("t4_busy_end", 32'(bus.busy), 32'h0);

        // Alignment table: byte odd ok, half odd err, size 11 treated as word, half even ok
        mem_lat = 1;
        bus.d_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle(); bus.d_req = 1'b1; bus.d_size = mis_size[i]; bus.d_addr = mis_addr[i]; settle();
            chk("al_gnt", 32'(bus.d_gnt), 32'h1);
            cycle(); bus.d_req = 1'b0; settle();
            chk("al_err", 32'(bus.d_err), 32'(mis_err[i]));
            cycle(); settle();
        end

        // 6: data request raised while a fetch is in flight
        mem_lat = 2;
        cycle(); bus.if_req = 1'b1; bus.if_addr = 32'h180; settle();
        chk("t6_if_gnt", 32'(bus.if_gnt), 32'h1);
        cycle(); bus.if_req = 1'b0; bus.d_req = 1'b1; bus.d_size = 2'b10; bus.d_addr = 32'h44; settle();
        chk("t6_d_gnt_wait", 32'(bus.d_gnt), 32'h0);
        cycle(); settle();
        chk("t6_if_rvalid", 32'(bus.if_rvalid), 32'h1);
        chk("t6_d_gnt_resp", 32'(bus.d_gnt), 32'h0);
        mem_lat = 1;
        cycle(); settle();
        chk("t6_d_gnt_after", 32'(bus.d_gnt), 32'h1);
        cycle(); bus.d_req = 1'b0; settle();
        cycle(); settle();

        // 5: reset during WAIT, memory answers late
        mem_lat = 3;
        cycle(); bus.if_req = 1'b1; bus.if_addr = 32'h140; settle();
        chk("t5_if_gnt", 32'(bus.if_gnt), 32'h1);
        cycle(); rst = 1'b1; bus.d_req = 1'b1; sb.delete(); settle();
        cycle(); rst = 1'b0; bus.if_req = 1'b0; bus.d_req = 1'b0; settle();
        chk("t5_busy_after_rst", 32'(bus.busy), 32'h0);
        cycle(); settle();
        chk("t5_late_mem_rvalid", 32'(bus.mem_rvalid), 32'h1);
        chk("t5_no_if_rvalid", 32'(bus.if_rvalid), 32'h0);
        chk("t5_no_d_rvalid", 32'(bus.d_rvalid), 32'h0);
        chk("t5_busy_late", 32'(bus.busy), 32'h0);
        cycle(); settle();

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
